// File: rtl/seg_pkg.sv
// seg_pkg: shared state type and segment patterns for the 7-segment scan controller.
package seg_pkg;
  typedef enum logic {BLANK, SHOW} seg_state_t;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_DIGITS [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
endpackage

// File: rtl/seg_bcd_decode.sv
// seg_bcd_decode: combinational BCD to active-low {g,f,e,d,c,b,a}; codes above 9 show a dash.
module seg_bcd_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  assign o_seg = (i_bcd > 4'd9) ? SEG_DASH : SEG_DIGITS[i_bcd];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed common-anode display scanner with blanking gaps and frame-aligned updates.
// Define SEG_SCAN_LZ_BLANK_EN to suppress leading zeros (digit 0 always lights).
module seg_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] digits_in,
  input  logic              load,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);
  import seg_pkg::*;
  localparam int CW = $clog2(DIV > BLANK ? DIV : BLANK);
  localparam int IW = $clog2(NDIG);
  localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_M1 = CW'(BLANK - 1);
  localparam logic [IW-1:0] LAST     = IW'(NDIG - 1);
  seg_state_t        r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic [4*NDIG-1:0] r_pend, r_disp, w_pend_nxt, w_disp_nxt;
  logic [6:0]        r_seg, w_seg_nxt, w_dec;
  logic [NDIG-1:0]   r_an, w_an_nxt;
  logic              r_fd, w_fd_nxt, w_frame_start, w_lit, w_lz;
  logic [3:0]        w_bcd;
  assign w_frame_start = (r_state == seg_pkg::BLANK) && (r_cnt == BLANK_M1) && (r_idx == '0);
  assign w_pend_nxt    = load ? digits_in : r_pend;
  // The frame-start edge must decode the freshly latched frame, so look ahead at the next display value.
  assign w_disp_nxt    = w_frame_start ? w_pend_nxt : r_disp;
  assign w_bcd         = w_disp_nxt[4*w_idx_nxt +: 4];
  seg_bcd_decode u_dec (.i_bcd(w_bcd), .o_seg(w_dec));
`ifdef SEG_SCAN_LZ_BLANK_EN
  assign w_lz = (w_idx_nxt != '0) && ((w_disp_nxt >> (4*w_idx_nxt)) == '0);
`else
  assign w_lz = 1'b0;
`endif
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_fd_nxt    = 1'b0;
    if (r_state == seg_pkg::BLANK && r_cnt == BLANK_M1) begin
      w_state_nxt = SHOW;
      w_cnt_nxt   = '0;
    end else if (r_state == SHOW && r_cnt == DIV_M1) begin
      w_state_nxt = seg_pkg::BLANK;
      w_cnt_nxt   = '0;
      w_idx_nxt   = (r_idx == LAST) ? '0 : r_idx + 1'b1;
      w_fd_nxt    = (r_idx == LAST);
    end
    w_lit     = (w_state_nxt == SHOW) && !w_lz;
    w_seg_nxt = w_lit ? w_dec : SEG_OFF;
    w_an_nxt  = w_lit ? ~(NDIG'(1) << w_idx_nxt) : '1;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= seg_pkg::BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_pend  <= '0;
      r_disp  <= '0;
      r_seg   <= SEG_OFF;
      r_an    <= '1;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_pend  <= w_pend_nxt;
      r_disp  <= w_disp_nxt;
      r_seg   <= w_seg_nxt;
      r_an    <= w_an_nxt;
      r_fd    <= w_fd_nxt;
    end
  end
  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_fd;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan order, blanking, frame-aligned loads, decode and reset.
module tb_seg_scan_ctrl;
`ifdef SEG_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S7 = 7'b1111000, S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111, SO = 7'h7F;
  logic clk = 1'b0, rst = 1'b0, load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [6:0] seg;
  logic [3:0] an;
  logic frame_done;
  int cyc = 0, vectors = 0, misses = 0;
  seg_scan_ctrl #(.NDIG(4), .DIV(4), .BLANK(2)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .load(load),
    .seg(seg), .an(an), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask
  task automatic chk(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ef);
    vectors++;
    assert (an === ea && seg === es && frame_done === ef) else begin
      misses++;
      $error("FAIL %s @cyc%0d: an=%b seg=%b fd=%b, expected an=%b seg=%b fd=%b",
             tag, cyc, an, seg, frame_done, ea, es, ef);
    end
  endtask
  initial begin
    tick();
    cyc = 0;
    chk("reset", 4'b1111, SO, 1'b0);
    rst = 1'b1;
    goto(1);  chk("blank1", 4'b1111, SO, 1'b0);
    goto(2);  chk("first_lit", 4'b1110, S0, 1'b0);
    goto(5);  chk("d0_end", 4'b1110, S0, 1'b0);
    goto(6);  chk("gap", 4'b1111, SO, 1'b0);
    goto(23); chk("d3_zero", LZ ? 4'b1111 : 4'b0111, LZ ? SO : S0, 1'b0);
    goto(24); chk("fd_pulse", 4'b1111, SO, 1'b1);
    digits_in = 16'h1234;
    load = 1'b1;
    goto(25); chk("fd_one_cycle", 4'b1111, SO, 1'b0);
    goto(26); chk("load_at_start", 4'b1110, S4, 1'b0);
    load = 1'b0;
    goto(30); chk("gap_1234", 4'b1111, SO, 1'b0);
    goto(32); chk("d1_3", 4'b1101, S3, 1'b0);
    goto(38); chk("d2_2", 4'b1011, S2, 1'b0);
    goto(44); chk("d3_1", 4'b0111, S1, 1'b0);
    goto(48); chk("fd_frame1", 4'b1111, SO, 1'b1);
    goto(62);
    digits_in = 16'h9999;
    load = 1'b1;
    goto(63); chk("mid_d2_old", 4'b1011, S2, 1'b0);
    load = 1'b0;
    goto(68); chk("mid_d3_old", 4'b0111, S1, 1'b0);
    goto(74); chk("new_d0_9", 4'b1110, S9, 1'b0);
    goto(92); chk("new_d3_9", 4'b0111, S9, 1'b0);
    goto(93);
    digits_in = 16'hFA00;
    load = 1'b1;
    goto(94);
    load = 1'b0;
    goto(98);  chk("fa00_d0", 4'b1110, S0, 1'b0);
    goto(104); chk("fa00_d1", 4'b1101, S0, 1'b0);
    goto(110); chk("fa00_d2_dash", 4'b1011, SD, 1'b0);
    goto(116); chk("fa00_d3_dash", 4'b0111, SD, 1'b0);
    goto(117);
    digits_in = 16'h0070;
    load = 1'b1;
    goto(118);
    load = 1'b0;
    goto(122); chk("lz_d0", 4'b1110, S0, 1'b0);
    goto(128); chk("lz_d1_7", 4'b1101, S7, 1'b0);
    goto(134); chk("lz_d2", LZ ? 4'b1111 : 4'b1011, LZ ? SO : S0, 1'b0);
    goto(140); chk("lz_d3", LZ ? 4'b1111 : 4'b0111, LZ ? SO : S0, 1'b0);
    goto(152); chk("pre_rst_d1", 4'b1101, S7, 1'b0);
    rst = 1'b0;
    tick();
    cyc = 0;
    chk("rst_mid_show", 4'b1111, SO, 1'b0);
    rst = 1'b1;
    goto(2); chk("restart_d0", 4'b1110, S0, 1'b0);
    goto(8); chk("disp_cleared_d1", LZ ? 4'b1111 : 4'b1101, LZ ? SO : S0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display on the Bit Counter FPGA board. It sequences one shared BCD-to-segment decoder across `NDIG` digits, driving active-low anode enables. A blanking gap between digits suppresses ghosting. New digit values are accepted through a load strobe and applied only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the bit-counter result logic and the board's segment and anode pins.

## Interface
Parameters:
- `NDIG`, 4: number of digits scanned; 2 to 8.
- `DIV`, 50000: clock cycles each digit is lit (SHOW phase); ≥2.
- `BLANK`, 16: clock cycles all anodes are off before each digit (BLANK phase); ≥1.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `digits_in`  in  4*NDIG: BCD digits; digit i is `digits_in[4i+3:4i]`, and digit 0 is rightmost.
- `load`  in  1: one-cycle strobe that captures `digits_in`.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active-low.
- `an`  out  NDIG: anode enables, active-low, one-hot-low or all high.
- `frame_done`  out  1: one-cycle pulse at the end of the last digit's SHOW phase.

## Operation
- FSM states: BLANK and SHOW. A phase counter of width `$clog2(max(DIV,BLANK))` and a digit index of width `$clog2(NDIG)` control the sequence.
- BLANK state:
  - `an` is all ones and `seg` is `7'h7F`.
  - After `BLANK` cycles, go to SHOW for the current index.
- SHOW state:
  - `an[idx]` is 0; every other `an` bit is 1.
  - `seg` is the decoded value of digit `idx` from the display register.
  - After `DIV` cycles, go to BLANK and advance the index.
  - The index wraps from `NDIG-1` to 0. `frame_done` pulses on that wrap cycle.
- Pending register: `load`=1 captures `digits_in`; the last load wins.
- Display register: updated from pending at frame start, defined as the BLANK→SHOW transition with `idx`=0.
  - If `load` is high on that same cycle, `digits_in` goes straight into the display register and the pending register.
- Decode, with a 0 bit meaning segment lit:
  - 0=`7'b1000000`, 1=`7'b1111001`, 2=`7'b0100100`, 3=`7'b0110000`, 4=`7'b0011001`
  - 5=`7'b0010010`, 6=`7'b0000010`, 7=`7'b1111000`, 8=`7'b0000000`, 9=`7'b0010000`
  - Codes 10 to 15 produce a dash, `7'b0111111`.
- Reset (`rst`=0 sampled at an edge):
  - State goes to BLANK with the counter and index at 0.
  - The pending and display registers clear to all zeros.
  - Outputs: `seg`=`7'h7F`, `an`=all ones, `frame_done`=0.
  - Reset asserted mid-SHOW blanks the display on the next edge.

## Timing
- All outputs are registered. `seg` and `an` change on the same edge.
- After reset release:
  - Cycles 0 to BLANK-1 are blank.
  - The first lit edge is cycle `BLANK`, showing digit 0 for `DIV` cycles.
- One frame lasts exactly `NDIG*(BLANK+DIV)` cycles.
- Load-to-display latency is at most one frame plus `BLANK` cycles. A load on the frame-start cycle appears on the next edge.
- `frame_done` occurs once per frame and is high for exactly 1 cycle.

## Configuration
- Macro: `SEG_SCAN_LZ_BLANK_EN`.
- When defined (leading-zero suppression):
  - During SHOW, digit i>0 keeps `an` all high if digit i and every higher digit in the display register equal 0.
  - Digit 0 always lights.
  - Timing and `frame_done` are unchanged.
- When undefined, every digit lights, including leading zeros.

## Structure
- Shared package `seg_pkg` holds:
  - the state enum `seg_state_t` {BLANK, SHOW};
  - the segment constants `SEG_OFF`=`7'h7F` and `SEG_DASH`=`7'b0111111`;
  - the 10-entry digit pattern constant.
- Sub-module `seg_bcd_decode`: combinational 4-bit to 7-bit decoder with no clock. It is instantiated once and its output is registered in `seg_scan_ctrl`.

## Test plan
- Parameters for all scenarios: NDIG=4, DIV=4, BLANK=2.
- Reset release with no load: `an` stays `4'b1111` for 2 cycles, then `4'b1110` with `seg`=`7'b1000000` for 4 cycles. `frame_done` pulses at cycle 24.
- Load `16'h1234`, then run a frame: the sequence shows `an`=1110 with `seg`=`7'b0011001` (4), then 1101→3, 1011→2, 0111→1. Each digit is lit for 4 cycles with 2 blank cycles between.
- Mid-frame load of `16'h9999` while digit 2 is shown: digits 2 and 3 still show old values, and 9s appear from the next frame.
- Load of `16'hFA00`: digits 3 and 2 show `7'b0111111`, and digits 1 and 0 show `7'b1000000`.
- With `SEG_SCAN_LZ_BLANK_EN` defined and load `16'h0070`: digits 3 and 2 keep `an` high, digit 1 shows 7, and digit 0 shows 0.
- `rst`=0 during SHOW of digit 1: next edge gives `an`=1111, `seg`=`7'h7F`, display register 0. After release, the sequence restarts from digit 0.
